mux_8_way_16_rr_arbiter: RTL and testbench
==========================================

// Module: mux_8_way_16_rr_arbiter
// PURPOSE
//  Shares one 16-bit datapath between 8 requesters, sequencing the select of an internal mux_8_way_16.
//  Round-robin grant; the winner's word is registered into a single output slot with valid/ready handshake.
//  Sits between 8 word producers (a..h) and one consumer (e.g. a memory-write or bus port).
// PARAMETERS
//  RESET_PTR  3'd0  requester index that has highest priority after reset
//  MAX_HOLD   4     max consecutive grants to one locked requester (ARB_LOCK_EN only); range 1..15
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  req        in   8   req[i]=1: requester i has a word on its data input
//  a..h       in   16  data of requesters 0..7; must be stable while req[i]=1 and ack[i]=0
//  ack        out  8   one-hot pulse, 1 cycle: requester i's word was captured this edge
//  out_valid  out  1   output slot holds a word
//  out_ready  in   1   consumer accepts out_data when out_valid & out_ready
//  out_data   out  16  captured word
//  out_id     out  3   index of the requester that supplied out_data
//  lock       in   8   (ARB_LOCK_EN only) lock[i]=1 with req[i]: keep grant on i for a burst
// BEHAVIOUR
//  Reset: out_valid=0, out_data=16'h0, out_id=3'd0, ack=8'h00, ptr=RESET_PTR, hold_cnt=0, state=EMPTY.
//  Reset mid-operation: held word discarded without handshake; no ack pulse on the reset cycle.
//  States: EMPTY (out_valid=0), FULL (out_valid=1).
//  load = (state==EMPTY) | (out_ready) -- slot is free now or is being drained this edge.
//  Grant: if load & |req, winner = first i with req[i]=1 scanning ptr, ptr+1, ... ptr+7 (mod 8).
//   Combinationally: sel=winner drives mux_8_way_16; ack[winner]=1 in the same cycle.
//   Edge: out_data<=mux out, out_id<=winner, out_valid<=1, state->FULL, ptr<=winner+1 (3-bit wrap 7->0).
//  No grant when load & ~|req: EMPTY stays EMPTY; FULL with out_ready -> EMPTY, out_valid<=0.
//  FULL & ~out_ready: everything holds; ack=0; req changes ignored.
//  Simultaneous drain + grant: back-to-back words, out_valid stays 1, one word per cycle throughput.
//  Latency: req[i] rises with slot free at cycle N -> ack[i] in N, out_valid/out_data visible at N+1.
//  Requester must drop or advance its word the cycle after ack; req held high = new word.
//  ack is zero whenever no capture happens; at most one ack bit is set (one-hot or zero).
//  Fairness: any requester with req held waits at most 7 grants (no lock).
// CONFIGURATION
//  Macro ARB_LOCK_EN defined: lock port present; if winner had lock[winner]=1, ptr stays at winner
//   (not winner+1) and hold_cnt increments; once hold_cnt reaches MAX_HOLD, or lock/req drops,
//   ptr<=winner+1 and hold_cnt<=0. Worst-case wait becomes 7*MAX_HOLD grants.
//  Undefined: no lock port, no hold_cnt, pure round-robin as above; MAX_HOLD unused.
// STRUCTURE
//  Package mux_arb_pkg: localparam NUM_REQ=8, SEL_W=3, WORD_W=16; typedef logic [SEL_W-1:0] sel_t;
//   typedef enum logic {EMPTY, FULL} arb_state_t; function sel_t rr_pick(req, ptr).
//  One sub-module: existing mux_8_way_16 instance for data selection (select=winner).
//  Rotating priority picker, pointer, hold counter, output register inline in this module.
// TESTING
//  Reset, req=8'h00 for 5 cycles -> out_valid=0, ack=0 every cycle, out_id=0.
//  req=8'hFF, out_ready=1 constant, a..h = 5555,AAAA,00FF,FF00,3333,CCCC,0F0F,F0F0
//   -> out_id 0,1,..,7,0 on consecutive cycles, out_data matches, one ack bit per cycle.
//  req=8'h24 (2,5), ptr=3 after prior grant of 2 -> grant 5 first (out_data=CCCC), then 2 (00FF).
//  Grant 3 (FF00), hold out_ready=0 for 4 cycles with req=8'hFF -> out_valid,out_data,out_id stable,
//   ack=0; out_ready=1 -> next grant id 4 in the drain cycle, out_valid stays 1.
//  Reset asserted while FULL -> next cycle out_valid=0, ack=0; after release first grant is RESET_PTR.
//  ARB_LOCK_EN, MAX_HOLD=4, req=8'h03, lock=8'h01 -> ids 0,0,0,0,1,0,0,0,0,1; undefined build -> 0,1,0,1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin word arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int WORD_W  = 16;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [3:0]        hold_t;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  // First requester with req set, scanning ptr, ptr+1, ... ptr+7 (3-bit wrap).
  // Returns ptr when nothing is requesting; callers qualify with |req.
  function automatic sel_t rr_pick(input logic [NUM_REQ-1:0] req, input sel_t ptr);
    sel_t idx;
    sel_t pick;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + sel_t'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_8_way_16.sv
// Plain 8-input, 16-bit combinational word selector.
module mux_8_way_16 (
  input  logic [2:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [15:0] out
);

  // Route the selected input word to the output.
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/mux_8_way_16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit datapath between 8 requesters.
// The granted word is captured into a single valid/ready output slot.
// Optional burst locking is enabled by defining ARB_LOCK_EN (adds the lock
// port and a per-burst hold counter bounded by MAX_HOLD).
module mux_8_way_16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter sel_t RESET_PTR = 3'd0,
  parameter int   MAX_HOLD  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
`ifdef ARB_LOCK_EN
  input  logic [7:0]  lock,
`endif
  output logic [7:0]  ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_id
);

  // Hold limit must fit the 4-bit counter and allow at least one grant.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..15");
  end

  arb_state_t state_q, state_d;
  sel_t       ptr_q, ptr_d;
  word_t      data_q, data_d;
  sel_t       id_q, id_d;
  sel_t       winner;
  word_t      mux_out;
  logic       load;
  logic       grant;
`ifdef ARB_LOCK_EN
  hold_t      hold_cnt_q, hold_cnt_d;
  hold_t      hold_inc;
`endif

  mux_8_way_16 u_mux (
    .sel (winner),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .out (mux_out)
  );

  // Pick the winner, pulse its ack, and compute the next slot/pointer state.
  always_comb begin
    load    = (state_q == EMPTY) || out_ready;
    winner  = rr_pick(req, ptr_q);
    grant   = load && (|req) && !reset;
    ack     = 8'h00;
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
`ifdef ARB_LOCK_EN
    hold_cnt_d = hold_cnt_q;
    // A locked burst continues only while the same requester keeps winning.
    hold_inc   = ((winner == ptr_q) ? hold_cnt_q : 4'd0) + 4'd1;
`endif
    if (grant) begin
      ack[winner] = 1'b1;
      data_d      = mux_out;
      id_d        = winner;
      state_d     = FULL;
      ptr_d       = winner + sel_t'(1);
`ifdef ARB_LOCK_EN
      hold_cnt_d  = 4'd0;
      if (lock[winner] && (hold_inc < hold_t'(MAX_HOLD))) begin
        ptr_d      = winner;
        hold_cnt_d = hold_inc;
      end
`endif
    end else if (load) begin
      state_d = EMPTY;
    end
  end

  // Slot, pointer and (optional) burst counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= RESET_PTR;
      data_q  <= '0;
      id_q    <= '0;
`ifdef ARB_LOCK_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
`ifdef ARB_LOCK_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_mux_8_way_16_rr_arbiter.sv
// Self-checking bench for mux_8_way_16_rr_arbiter: directed scenarios plus a
// randomized phase, all checked against a behavioural reference model.
module tb_mux_8_way_16_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] w [8];
  logic [7:0]  lock;
  logic [7:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_id;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit        m_valid;
  bit [15:0] m_data;
  int        m_id;
  int        m_ptr;
  int        m_burst;     // consecutive locked grants to requester m_ptr
  logic [7:0] last_ack;

  always #5 clk = ~clk;

  mux_8_way_16_rr_arbiter #(.RESET_PTR(3'd0), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (w[0]),
    .b         (w[1]),
    .c         (w[2]),
    .d         (w[3]),
    .e         (w[4]),
    .f         (w[5]),
    .g         (w[6]),
    .h         (w[7]),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner from the rotating-priority rule, or -1 when no capture happens.
  function automatic int model_winner();
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < 8; k++) begin
      if (req[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    end
    return -1;
  endfunction

  // One clock: check ack before the edge, advance model, check slot after.
  task automatic step(input string tag);
    int win;
    logic [7:0] exp_ack;
    bit locked;
    #1;
    win = model_winner();
    exp_ack = (win >= 0) ? (8'h01 << win) : 8'h00;
    last_ack = ack;
    check({tag, "/ack"}, {8'h00, ack}, {8'h00, exp_ack});
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_burst = 0;
    end else if (win >= 0) begin
      m_valid = 1; m_data = w[win]; m_id = win;
`ifdef ARB_LOCK_EN
      locked = lock[win];
`else
      locked = 0;
`endif
      if (locked) begin
        m_burst = (win == m_ptr) ? m_burst + 1 : 1;
        if (m_burst >= 4) begin
          m_ptr = (win + 1) % 8; m_burst = 0;
        end else begin
          m_ptr = win;
        end
      end else begin
        m_ptr = (win + 1) % 8; m_burst = 0;
      end
    end else if (!m_valid || out_ready) begin
      m_valid = 0;
    end
    #1;
    check({tag, "/valid"}, {15'h0, out_valid}, {15'h0, m_valid});
    check({tag, "/data"}, out_data, m_data);
    check({tag, "/id"}, {13'h0, out_id}, m_id[15:0]);
  endtask

  task automatic do_reset();
    reset = 1; req = 8'h00;
    step("reset");
    reset = 0;
  endtask

  initial begin
    logic [15:0] pat [8];
    int exp_ids [10];
    pat = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00, 16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};
    reset = 1; req = 0; out_ready = 0; lock = 0; last_ack = 0;
    for (int i = 0; i < 8; i++) w[i] = pat[i];
    m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_burst = 0;
    @(posedge clk);
    #1;

    // Idle after reset
    do_reset();
    check("rst_valid", {15'h0, out_valid}, 16'h0);
    check("rst_id", {13'h0, out_id}, 16'h0);
    for (int i = 0; i < 5; i++) begin
      step("idle");
      check("idle_valid", {15'h0, out_valid}, 16'h0);
    end

    // Full request, always ready: ids 0..7,0
    req = 8'hFF; out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      step("rr_all");
      check("rr_id", {13'h0, out_id}, 16'(i % 8));
      check("rr_data", out_data, pat[i % 8]);
    end

    // Requesters 2 and 5 with ptr at 3
    do_reset();
    req = 8'h04; step("pre2");
    req = 8'h24; step("r24a");
    check("r24a_data", out_data, 16'hCCCC);
    step("r24b");
    check("r24b_data", out_data, 16'h00FF);

    // Backpressure holding requester 3's word
    do_reset();
    req = 8'h08; out_ready = 1; step("g3");
    req = 8'hFF; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step("stall");
      check("stall_ack", {8'h0, last_ack}, 16'h0);
      check("stall_data", out_data, 16'hFF00);
      check("stall_id", {13'h0, out_id}, 16'd3);
    end
    out_ready = 1; step("drain");
    check("drain_ack", {8'h0, last_ack}, 16'h0010);
    check("drain_id", {13'h0, out_id}, 16'd4);
    check("drain_valid", {15'h0, out_valid}, 16'h1);

    // Reset while FULL
    out_ready = 0; reset = 1; step("rst_full");
    check("rst_full_ack", {8'h0, last_ack}, 16'h0);
    check("rst_full_valid", {15'h0, out_valid}, 16'h0);
    reset = 0; out_ready = 1; step("post_rst");
    check("post_rst_id", {13'h0, out_id}, 16'd0);

    // Lock burst pattern (plain round-robin without the lock feature)
    do_reset();
`ifdef ARB_LOCK_EN
    exp_ids = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    lock = 8'h01;
`else
    exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    req = 8'h03; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      step("lock");
      check("lock_id", {13'h0, out_id}, 16'(exp_ids[i]));
    end
    lock = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 8'h00;
      out_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 49) == 0);
      lock = 8'($urandom);
      for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
      step("rand");
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
